// File: rtl/grass_sway_sched_pkg.sv
// Shared video package for the grass background path.
// Holds the sway state encoding, the visible raster size and the default
// sway limits, so the renderer and the scheduler agree on the offset range.
package grass_sway_sched_pkg;

    typedef enum logic [1:0] {
        RISE     = 2'd0,
        DWELL_HI = 2'd1,
        FALL     = 2'd2,
        DWELL_LO = 2'd3
    } sway_state_e;

    localparam int H_VISIBLE = 640;
    localparam int V_VISIBLE = 480;

    localparam int MVMT_W_DEF       = 6;
    localparam int MVMT_MIN_DEF     = 1;
    localparam int MVMT_MAX_DEF     = 32;
    localparam int GUST_MAX_DEF     = 40;
    localparam int DWELL_FRAMES_DEF = 4;
    localparam int GUST_FRAMES_DEF  = 60;
    localparam int DIV_W_DEF        = 4;

    // Dwell counter load value; a dwell of zero frames still holds for one step.
    function automatic int dwell_load(input int frames);
        return (frames < 1) ? 0 : frames - 1;
    endfunction

endpackage

// File: rtl/grass_sway_sched_if.sv
// Control/result bundle between the frame timing side and the sway scheduler.
//   frame_start : one-cycle pulse at the first pixel of each frame
//   enable      : 1 = animate, 0 = freeze
//   speed_div   : frames per step minus one
//   gust_req    : single-cycle gust request
//   mvmt        : sway offset to the renderer
//   mvmt_dir    : 1 = rising, 0 = falling or dwelling low
//   gust_active : gust window in progress
//   step_pulse  : one-cycle pulse after each step
// master = the side driving frame timing/control, slave = the scheduler.
interface grass_sway_sched_if import grass_sway_sched_pkg::*; #(
    parameter int MVMT_W = MVMT_W_DEF,
    parameter int DIV_W  = DIV_W_DEF
) ();

    logic              frame_start;
    logic              enable;
    logic [DIV_W-1:0]  speed_div;
    logic              gust_req;
    logic [MVMT_W-1:0] mvmt;
    logic              mvmt_dir;
    logic              gust_active;
    logic              step_pulse;

    modport master (
        output frame_start, enable, speed_div, gust_req,
        input  mvmt, mvmt_dir, gust_active, step_pulse
    );

    modport slave (
        input  frame_start, enable, speed_div, gust_req,
        output mvmt, mvmt_dir, gust_active, step_pulse
    );

endinterface

// File: rtl/grass_sway_sched_frame_div.sv
// Frame divider: counts enabled frames and raises step_o on the frame that
// completes a period of div_i+1 frames. Reused by other animated backgrounds.
//   clk_i  : clock
//   rst_i  : synchronous active-high reset
//   tick_i : enabled frame boundary
//   div_i  : frames per step minus one
//   step_o : combinational step strobe, valid in the tick_i cycle
module sway_frame_div #(
    parameter int DIV_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             tick_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             step_o
);

    logic [DIV_W-1:0] frame_cnt_q, frame_cnt_d;

    // ">=" rather than "==": lowering div_i mid-count steps at once instead
    // of running the counter around through its full range.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        step_o      = 1'b0;
        if (tick_i) begin
            if (frame_cnt_q >= div_i) begin
                frame_cnt_d = '0;
                step_o      = 1'b1;
            end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

endmodule

// File: rtl/grass_sway_sched.sv
// Frame-synchronous sway scheduler for the grass renderer. Steps the sway
// offset up and down between its turn-around points at a programmable frame
// rate, dwells at each end, and widens the upper limit during a gust.
// Every output changes only on frame boundaries so a frame is never torn.
//   clk_i   : clock
//   rst_i   : synchronous active-high reset
//   sway_if : control inputs and sway outputs (slave side)
//
// state    | meaning
// RISE     | mvmt climbs by one per step towards hi_lim
// DWELL_HI | mvmt held at the upper turn-around
// FALL     | mvmt drops by one per step towards MVMT_MIN
// DWELL_LO | mvmt held at MVMT_MIN, direction still reported as falling
module grass_sway_sched import grass_sway_sched_pkg::*; #(
    parameter int MVMT_W       = MVMT_W_DEF,
    parameter int MVMT_MIN     = MVMT_MIN_DEF,
    parameter int MVMT_MAX     = MVMT_MAX_DEF,
    parameter int GUST_MAX     = GUST_MAX_DEF,
    parameter int DWELL_FRAMES = DWELL_FRAMES_DEF,
    parameter int GUST_FRAMES  = GUST_FRAMES_DEF,
    parameter int DIV_W        = DIV_W_DEF
) (
    input  logic               clk_i,
    input  logic               rst_i,
    grass_sway_sched_if.slave  sway_if
);

    // One spare bit so mvmt+1 / mvmt-1 never wrap.
    localparam int AW    = MVMT_W + 1;
    localparam int DWL_W = (DWELL_FRAMES > 1) ? $clog2(DWELL_FRAMES) : 1;
    localparam int GST_W = (GUST_FRAMES > 1) ? $clog2(GUST_FRAMES) : 1;

    localparam logic [AW-1:0]    MIN_V      = AW'(MVMT_MIN);
    localparam logic [AW-1:0]    MAX_V      = AW'(MVMT_MAX);
    localparam logic [AW-1:0]    GUST_V     = AW'(GUST_MAX);
    localparam logic [DWL_W-1:0] DWELL_LOAD = DWL_W'(dwell_load(DWELL_FRAMES));
    localparam logic [GST_W-1:0] GUST_LOAD  = GST_W'((GUST_FRAMES > 0) ? GUST_FRAMES - 1 : 0);

    sway_state_e       state_q, state_d;
    logic [MVMT_W-1:0] mvmt_q, mvmt_d;
    logic              dir_q, dir_d;
    logic [DWL_W-1:0]  dwell_q, dwell_d;
    logic [GST_W-1:0]  gust_cnt_q, gust_cnt_d;
    logic              gust_active_q, gust_active_d;
    logic              gust_pend_q, gust_pend_d;
    logic              step_pulse_q, step_pulse_d;

    logic          tick;
    logic          take_gust;
    logic          step;
    logic [AW-1:0] hi_lim;
    logic [AW-1:0] mvmt_ext;
    logic [AW-1:0] mvmt_inc;
    logic [AW-1:0] mvmt_dec;
    logic          over_normal;

    assign tick      = sway_if.frame_start & sway_if.enable;
    // A request arriving with the frame boundary is taken in that same cycle.
    assign take_gust = tick & (gust_pend_q | sway_if.gust_req);

    sway_frame_div #(.DIV_W(DIV_W)) u_frame_div (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .tick_i (tick),
        .div_i  (sway_if.speed_div),
        .step_o (step)
    );

    assign hi_lim      = gust_active_q ? GUST_V : MAX_V;
    assign mvmt_ext    = {1'b0, mvmt_q};
    assign mvmt_inc    = mvmt_ext + 1'b1;
    assign mvmt_dec    = mvmt_ext - 1'b1;
    // Gust over while still above the normal range: turn round now rather
    // than clamping mvmt down to MVMT_MAX in one jump.
    assign over_normal = !gust_active_q && (mvmt_ext > MAX_V);

    always_comb begin
        state_d       = state_q;
        mvmt_d        = mvmt_q;
        dir_d         = dir_q;
        dwell_d       = dwell_q;
        gust_cnt_d    = gust_cnt_q;
        gust_active_d = gust_active_q;
        gust_pend_d   = gust_pend_q;
        step_pulse_d  = 1'b0;

        if (take_gust) begin
            gust_pend_d   = 1'b0;
            gust_cnt_d    = GUST_LOAD;
            gust_active_d = 1'b1;
        end else begin
            if (sway_if.gust_req) begin
                gust_pend_d = 1'b1;
            end
            if (tick && gust_active_q) begin
                if (gust_cnt_q == '0) begin
                    gust_active_d = 1'b0;
                end else begin
                    gust_cnt_d = gust_cnt_q - 1'b1;
                end
            end
        end

        if (step) begin
            step_pulse_d = 1'b1;
            case (state_q)
                RISE: begin
                    if (over_normal) begin
                        state_d = FALL;
                        dir_d   = 1'b0;
                    end else if (mvmt_inc >= hi_lim) begin
                        mvmt_d  = hi_lim[MVMT_W-1:0];
                        dwell_d = DWELL_LOAD;
                        state_d = DWELL_HI;
                        dir_d   = 1'b1;
                    end else begin
                        mvmt_d = mvmt_inc[MVMT_W-1:0];
                        dir_d  = 1'b1;
                    end
                end
                DWELL_HI: begin
                    if (over_normal || dwell_q == '0) begin
                        state_d = FALL;
                        dir_d   = 1'b0;
                    end else begin
                        dwell_d = dwell_q - 1'b1;
                    end
                end
                FALL: begin
                    dir_d = 1'b0;
                    if (mvmt_dec <= MIN_V) begin
                        mvmt_d  = MIN_V[MVMT_W-1:0];
                        dwell_d = DWELL_LOAD;
                        state_d = DWELL_LO;
                    end else begin
                        mvmt_d = mvmt_dec[MVMT_W-1:0];
                    end
                end
                DWELL_LO: begin
                    if (dwell_q == '0) begin
                        state_d = RISE;
                        dir_d   = 1'b1;
                    end else begin
                        dwell_d = dwell_q - 1'b1;
                    end
                end
                default: begin
                    state_d = RISE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= RISE;
            mvmt_q        <= MIN_V[MVMT_W-1:0];
            dir_q         <= 1'b1;
            dwell_q       <= '0;
            gust_cnt_q    <= '0;
            gust_active_q <= 1'b0;
            gust_pend_q   <= 1'b0;
            step_pulse_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            mvmt_q        <= mvmt_d;
            dir_q         <= dir_d;
            dwell_q       <= dwell_d;
            gust_cnt_q    <= gust_cnt_d;
            gust_active_q <= gust_active_d;
            gust_pend_q   <= gust_pend_d;
            step_pulse_q  <= step_pulse_d;
        end
    end

    assign sway_if.mvmt        = mvmt_q;
    assign sway_if.mvmt_dir    = dir_q;
    assign sway_if.gust_active = gust_active_q;
    assign sway_if.step_pulse  = step_pulse_q;

endmodule

// File: tb/tb_grass_sway_sched.sv
// Self-checking bench for grass_sway_sched: a frame-level sway model is
// compared with the DUT on every cycle, plus hand-computed checkpoints.
module tb_grass_sway_sched;

    localparam int M_MIN  = 1;
    localparam int M_MAX  = 32;
    localparam int G_MAX  = 40;
    localparam int DWELL  = 4;
    localparam int GUST   = 60;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    grass_sway_sched_if sif ();

    grass_sway_sched dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .sway_if (sif)
    );

    int n_chk  = 0;
    int n_fail = 0;

    function automatic void check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Frame-level model: offset, direction of travel, remaining dwell steps,
    // remaining gust frames.
    int m_mv, m_dwell, m_gleft, m_fc;
    bit m_up, m_dir, m_gon, m_pend, m_sp;
    bit model_ok = 1'b0;

    function automatic void model_step(input int lim, input bit gon_old);
        bit tame;
        int dw;
        tame = !gon_old && (m_mv > M_MAX);
        dw   = (DWELL < 1) ? 1 : DWELL;
        if (m_dwell > 0) begin
            if (m_up && tame) begin
                m_dwell = 0;
                m_up    = 1'b0;
            end else begin
                m_dwell--;
                if (m_dwell == 0) m_up = !m_up;
            end
        end else if (m_up) begin
            if (tame) m_up = 1'b0;
            else if (m_mv + 1 >= lim) begin
                m_mv    = lim;
                m_dwell = dw;
            end else m_mv++;
        end else begin
            if (m_mv - 1 <= M_MIN) begin
                m_mv    = M_MIN;
                m_dwell = dw;
            end else m_mv--;
        end
        m_dir = m_up;
    endfunction

    always @(posedge clk) begin : model
        int lim;
        bit go;
        bit gon_old;
        if (rst) begin
            m_mv = M_MIN; m_up = 1'b1; m_dir = 1'b1; m_dwell = 0;
            m_gleft = 0; m_gon = 1'b0; m_pend = 1'b0; m_fc = 0; m_sp = 1'b0;
            model_ok = 1'b1;
        end else begin
            m_sp = 1'b0;
            if (sif.frame_start && sif.enable) begin
                gon_old = m_gon;
                lim     = gon_old ? G_MAX : M_MAX;
                go      = (m_fc >= int'(sif.speed_div));
                m_fc    = go ? 0 : m_fc + 1;
                if (m_pend || sif.gust_req) begin
                    m_gon = 1'b1; m_gleft = GUST; m_pend = 1'b0;
                end else if (m_gon) begin
                    m_gleft--;
                    if (m_gleft == 0) m_gon = 1'b0;
                end
                if (go) begin
                    m_sp = 1'b1;
                    model_step(lim, gon_old);
                end
            end else if (sif.gust_req) begin
                m_pend = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            check("mvmt",        int'(sif.mvmt),        m_mv);
            check("mvmt_dir",    int'(sif.mvmt_dir),    int'(m_dir));
            check("gust_active", int'(sif.gust_active), int'(m_gon));
            check("step_pulse",  int'(sif.step_pulse),  int'(m_sp));
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        sif.frame_start = 1'b0;
        sif.gust_req    = 1'b0;
        sif.enable      = 1'b1;
        sif.speed_div   = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One idle cycle, then a frame_start cycle; returns where the result is visible.
    task automatic frame(input bit g);
        @(negedge clk);
        sif.frame_start = 1'b1;
        sif.gust_req    = g;
        @(negedge clk);
        sif.frame_start = 1'b0;
        sif.gust_req    = 1'b0;
    endtask

    task automatic greq_pulse();
        @(negedge clk);
        sif.gust_req = 1'b1;
        @(negedge clk);
        sif.gust_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        bit ended;
        rst = 1'b1;
        sif.frame_start = 1'b0;
        sif.gust_req    = 1'b0;
        sif.enable      = 1'b1;
        sif.speed_div   = '0;

        // Reset values, then a full rise and turn-around at speed 0.
        do_reset();
        check("rst_mvmt", int'(sif.mvmt), 1);
        check("rst_dir",  int'(sif.mvmt_dir), 1);
        check("rst_gust", int'(sif.gust_active), 0);
        check("rst_pulse", int'(sif.step_pulse), 0);
        for (int k = 1; k <= 40; k++) begin
            frame(1'b0);
            if (k == 1)  check("t1_first_step", int'(sif.mvmt), 2);
            if (k == 1)  check("t1_first_pulse", int'(sif.step_pulse), 1);
            if (k == 31) check("t1_peak", int'(sif.mvmt), 32);
            if (k == 35) check("t1_dwell_last", int'(sif.mvmt), 32);
            if (k == 36) check("t1_fall_first", int'(sif.mvmt), 31);
            if (k == 36) check("t1_fall_dir", int'(sif.mvmt_dir), 0);
        end

        // Divided stepping and lowering speed_div mid-count.
        do_reset();
        sif.speed_div = 4'd3;
        for (int k = 1; k <= 8; k++) begin
            frame(1'b0);
            check("t2_pulse", int'(sif.step_pulse), (k % 4 == 0) ? 1 : 0);
            check("t2_mvmt", int'(sif.mvmt), 1 + k / 4);
        end
        sif.speed_div = 4'd9;
        repeat (5) frame(1'b0);
        check("t2_slow_hold", int'(sif.mvmt), 3);
        sif.speed_div = 4'd2;
        frame(1'b0);
        check("t2_lowered_div", int'(sif.mvmt), 4);

        // Gust from mvmt=20 rising.
        do_reset();
        repeat (19) frame(1'b0);
        check("t3_start", int'(sif.mvmt), 20);
        greq_pulse();
        check("t3_pend_only", int'(sif.gust_active), 0);
        frame(1'b0);
        check("t3_gust_on", int'(sif.gust_active), 1);
        check("t3_mvmt21", int'(sif.mvmt), 21);
        for (int k = 1; k <= 62; k++) begin
            frame(1'b0);
            if (k == 19) check("t3_gust_peak", int'(sif.mvmt), 40);
            if (k == 59) check("t3_gust_last", int'(sif.gust_active), 1);
            if (k == 60) check("t3_gust_off", int'(sif.gust_active), 0);
            if (k == 62) check("t3_bottom", int'(sif.mvmt), 1);
        end

        // Freeze at mvmt=15, gust requested while frozen; later freeze mid-dwell.
        do_reset();
        repeat (14) frame(1'b0);
        sif.enable = 1'b0;
        greq_pulse();
        repeat (10) frame(1'b0);
        check("t4_frz_mvmt", int'(sif.mvmt), 15);
        check("t4_frz_dir", int'(sif.mvmt_dir), 1);
        check("t4_frz_gust", int'(sif.gust_active), 0);
        sif.enable = 1'b1;
        frame(1'b0);
        check("t4_resume", int'(sif.mvmt), 16);
        check("t4_pend_kept", int'(sif.gust_active), 1);
        for (int j = 1; j <= 29; j++) begin
            if (j == 27) begin
                sif.enable = 1'b0;
                repeat (5) frame(1'b0);
                sif.enable = 1'b1;
            end
            frame(1'b0);
            if (j == 28) check("t4_dwell_done", int'(sif.mvmt), 40);
            if (j == 29) check("t4_fall", int'(sif.mvmt), 39);
        end

        // Reset mid-gust at mvmt=38 with a simultaneous gust request.
        do_reset();
        frame(1'b1);
        repeat (36) frame(1'b0);
        check("t5_pre_mvmt", int'(sif.mvmt), 38);
        check("t5_pre_gust", int'(sif.gust_active), 1);
        @(negedge clk);
        rst = 1'b1;
        sif.gust_req = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sif.gust_req = 1'b0;
        check("t5_rst_mvmt", int'(sif.mvmt), 1);
        check("t5_rst_dir", int'(sif.mvmt_dir), 1);
        check("t5_rst_gust", int'(sif.gust_active), 0);
        frame(1'b0);
        check("t5_req_dropped", int'(sif.gust_active), 0);

        // Gust extended by a second request 30 frames in: 90 frames total.
        do_reset();
        cnt = 0;
        ended = 1'b0;
        frame(1'b1);
        if (sif.gust_active) cnt++;
        for (int k = 1; k <= 29; k++) begin
            frame(1'b0);
            if (sif.gust_active) cnt++;
        end
        frame(1'b1);
        if (sif.gust_active) cnt++;
        for (int k = 0; k < 120; k++) begin
            frame(1'b0);
            if (sif.gust_active) cnt++;
            else begin
                ended = 1'b1;
                break;
            end
        end
        check("t6_gust_len", cnt, 90);
        check("t6_gust_ended", int'(ended), 1);

        // Gust ending while above the normal range: turn round without a jump.
        do_reset();
        repeat (30) frame(1'b0);
        sif.speed_div = 4'd7;
        for (int k = 0; k <= 71; k++) begin
            frame(k == 0);
            if (k == 55) check("t7_high", int'(sif.mvmt), 38);
            if (k == 63) check("t7_turn_mvmt", int'(sif.mvmt), 38);
            if (k == 63) check("t7_turn_dir", int'(sif.mvmt_dir), 0);
            if (k == 71) check("t7_fall", int'(sif.mvmt), 37);
        end

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
